// File: rtl/tmrx_mix_pipe_pkg.sv
// Shared definitions for the tmrx_mix_pipe test design.
// Holds the mode encoding and the default parameter values.
package tmrx_mix_pipe_pkg;

    typedef enum logic {
        MODE_ACC = 1'b0,
        MODE_BYP = 1'b1
    } mix_mode_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 3;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/tmrx_mix_stage.sv
// One accumulate-and-mix stage: XOR-accumulates masked input beats, or
// passes them through untouched in bypass mode while the accumulator holds.
module tmrx_mix_stage
    import tmrx_mix_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic             clear_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] key_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o,
    (* tmrx_error_sink *)
    output logic             err_o
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_acc;

    logic             w_take;
    logic             w_byp;
    logic [WIDTH-1:0] w_acc_old;
    logic [WIDTH-1:0] w_mix;

    assign w_take    = adv_i & v_i;
    assign w_byp     = (mix_mode_e'(mode_i) == MODE_BYP);
    // A beat arriving on a clear edge mixes against a zeroed accumulator.
    assign w_acc_old = clear_i ? '0 : r_acc;
    assign w_mix     = w_acc_old ^ (d_i & key_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v   <= 1'b0;
            r_d   <= '0;
            r_acc <= '0;
        end else begin
            if (adv_i) begin
                r_v <= v_i;
            end
            if (w_take) begin
                r_d <= w_byp ? d_i : w_mix;
            end
            if (w_take && !w_byp) begin
                r_acc <= w_mix;
            end else if (clear_i) begin
                r_acc <= '0;
            end
        end
    end

    assign v_o   = r_v;
    assign d_o   = r_d;
    assign err_o = 1'b0;

endmodule

// File: rtl/tmrx_mix_pipe.sv
// STAGES-deep mix pipeline with a single global advance (valid/ready),
// a saturating output beat counter and an OR-collected error sink.
module tmrx_mix_pipe
    import tmrx_mix_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] key_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] beat_cnt_o,
    (* tmrx_error_sink *)
    output logic             err_o
);

    logic             w_adv;
    logic             w_hs;
    logic [STAGES:0]  w_v;
    logic [WIDTH-1:0] w_d [STAGES+1];
    logic [STAGES-1:0] w_err;
    logic [CNT_W-1:0] r_cnt;

    assign w_v[0] = in_valid_i;
    assign w_d[0] = in_data_i;

    assign out_valid_o = w_v[STAGES];
    assign out_data_o  = w_d[STAGES];

    // The whole pipe moves together whenever the last slot can drain.
    assign w_adv      = out_ready_i | ~out_valid_o;
    assign in_ready_o = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        tmrx_mix_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .adv_i   (w_adv),
            .clear_i (clear_i),
            .mode_i  (mode_i),
            .key_i   (key_i),
            .v_i     (w_v[k]),
            .d_i     (w_d[k]),
            .v_o     (w_v[k+1]),
            .d_o     (w_d[k+1]),
            .err_o   (w_err[k])
        );
    end

    assign w_hs = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_hs && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign beat_cnt_o = r_cnt;
    assign err_o      = |w_err;

endmodule

// File: doc/tmrx_mix_pipe.md
Name: tmrx_mix_pipe

Overview:
- Parametrised TMRX test design and successor to the single-register dummy.
- A WIDTH-bit datapath passes through STAGES identical accumulate-and-mix stages.
- Provides a valid/ready handshake with backpressure, a mode select, a synchronous clear and a saturating beat counter.
- Exercises TMRX triplication of pipelines, stall logic, counters and error-sink propagation through hierarchy (top plus STAGES instances of one sub-module).

Parameters:
- WIDTH, 8, datapath and accumulator width (>=1).
- STAGES, 3, number of mix stages (>=1); equals latency in cycles with no stall.
- CNT_W, 16, width of the output beat counter (>=1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous clear of all accumulators and the counter.
- mode_i  input  1  0 = accumulate, 1 = bypass (data passes, accumulators hold).
- key_i  input  WIDTH  mask ANDed with each stage's input data.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  input  WIDTH  input data.
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  downstream ready.
- out_data_o  output  WIDTH  output data (last stage d_q).
- beat_cnt_o  output  CNT_W  count of output handshakes, saturating.
- err_o  output  1  carries attribute (* tmrx_error_sink *).

Behaviour:
- Reset: all v_q, d_q, acc_q and beat_cnt go to 0. Outputs after reset: out_valid_o=0, out_data_o=0, beat_cnt_o=0, in_ready_o=1.
- Global advance: adv = out_ready_i | ~out_valid_o. in_ready_o = adv, combinational, no input-to-output path other than out_ready_i.
- Stage k (k=0..STAGES-1) has input v_in/d_in. Stage 0 takes in_valid_i/in_data_i; stage k>0 takes stage k-1 v_q/d_q.
- On a clock edge with adv=1:
  - v_q <= v_in.
  - If v_in & mode_i=0: acc_q <= acc_q ^ (d_in & key_i); d_q <= acc_q ^ (d_in & key_i).
  - If v_in & mode_i=1: acc_q holds; d_q <= d_in.
  - If ~v_in: acc_q and d_q hold (bubble does not disturb state).
- adv=0 (stall): all stage registers hold. Data accepted earlier is never lost or duplicated.
- mode_i is sampled per stage at the edge the beat enters that stage. It is not carried with the beat; a mode change mid-flight affects beats still in the pipe.
- clear_i=1 at an edge: every acc_q <= 0 and beat_cnt <= 0, regardless of adv.
  - v_q and d_q advance normally; a beat entering a stage on that edge uses acc_q=0 as the old value.
- beat_cnt increments on out_valid_o & out_ready_i unless clear_i. It saturates at 2^CNT_W-1 and never wraps.
- Latency: a beat accepted at edge n appears on out_valid_o after edge n+STAGES-1 when there is no stall. Sustained throughput is 1 beat/cycle with out_ready_i=1.
- err_o:
  - Driven constant 0 in non-triplicated RTL.
  - Each stage instance also has an err_o marked tmrx_error_sink (constant 0); the top ORs all stage err_o into its own err_o.
  - The TMRX pass rewires these ports; the RTL must not add any other logic on them.
- Reset asserted mid-operation: immediate asynchronous clear of all state. In-flight beats are dropped and out_valid_o deasserts without a handshake.

Decomposition:
- No shared package needed; all widths derive from parameters.
- One sub-module, tmrx_mix_stage (WIDTH): ports clk_i, rst_ni, adv_i, clear_i, mode_i, key_i, v_i, d_i, v_o, d_o, err_o (tmrx_error_sink).
- Top instantiates STAGES copies via a generate loop and holds adv, the counter and the err_o OR-reduction.

Test Plan:
- Basic accumulate: reset, mode=0, key=0xFF, out_ready=1; send 0x01, 0x02, 0x04 back-to-back. Expect out_data 0x01, 0x03, 0x06 on three consecutive valid cycles, first valid 2 edges after the first accept; beat_cnt_o=3.
- Bypass: mode=1, same inputs. Expect outputs 0x01, 0x02, 0x04 and all accumulators unchanged (still 0 after reset).
- Backpressure: hold out_ready=0 for 5 cycles while streaming 6 beats. Expect in_ready_o=0 once the pipe is full, out_data stable while stalled, and an identical output sequence to the unstalled run once released.
- Key mask: key=0x0F, input 0xF3. Expect output 0x03 from all three stages (0xF3&0x0F=0x03, then 0x03, then 0x03).
- Clear and saturation: CNT_W=2, push 5 beats. Expect beat_cnt_o 1, 2, 3, 3, 3; then pulse clear_i and expect beat_cnt_o=0 and the next beat 0x01 exits as 0x01.
- Async reset mid-stream: assert rst_ni low between edges with 2 beats in flight. Expect out_valid_o=0, out_data_o=0 and beat_cnt_o=0 immediately; err_o=0 throughout every test.
